// File: rtl/eth_tx_frame_arbiter.sv
// ---------------------------------------------------------------------------
// eth_tx_frame_arbiter
//
// Frame-granular round-robin arbiter that merges several 8-bit AXI-stream
// producers onto the single TX stream feeding the MAC TX frame FIFO. A grant
// is held from the first beat of a frame until its tlast. Frames longer than
// MAX_FRAME_LEN are cut: the last allowed beat is sent with tlast=1/tuser=1,
// and the remainder of the source frame is swallowed.
//
// Ports:
//   logic_clk, logic_rst     : clock, asynchronous active-high reset
//   s_axis_t{data,valid,ready,last,user} : PORTS packed source streams
//   m_axis_t{data,valid,ready,last,user} : registered merged output stream
//   grant_port               : index of the current / most recent grant
//   busy                     : high while a frame is owned (PASS or DISCARD)
//   status_frame_done        : 1-cycle pulse, frame completed normally
//   status_truncated         : 1-cycle pulse, frame cut at MAX_FRAME_LEN
// ---------------------------------------------------------------------------
module eth_tx_frame_arbiter #(
    parameter int PORTS         = 3,
    parameter int MAX_FRAME_LEN = 1522,
    parameter int LEN_WIDTH     = $clog2(MAX_FRAME_LEN + 1),
    parameter int SEL_WIDTH     = (PORTS > 1) ? $clog2(PORTS) : 1
) (
    input  logic                 logic_clk,
    input  logic                 logic_rst,

    input  logic [PORTS*8-1:0]   s_axis_tdata,
    input  logic [PORTS-1:0]     s_axis_tvalid,
    output logic [PORTS-1:0]     s_axis_tready,
    input  logic [PORTS-1:0]     s_axis_tlast,
    input  logic [PORTS-1:0]     s_axis_tuser,

    output logic [7:0]           m_axis_tdata,
    output logic                 m_axis_tvalid,
    input  logic                 m_axis_tready,
    output logic                 m_axis_tlast,
    output logic                 m_axis_tuser,

    output logic [SEL_WIDTH-1:0] grant_port,
    output logic                 busy,
    output logic                 status_frame_done,
    output logic                 status_truncated
);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_PASS    = 2'd1,
        ST_DISCARD = 2'd2
    } state_t;

    state_t                 state_reg, state_next;
    logic [SEL_WIDTH-1:0]   grant_reg, grant_next;
    logic [SEL_WIDTH-1:0]   last_grant_reg, last_grant_next;
    logic [LEN_WIDTH-1:0]   count_reg, count_next;

    logic [7:0]             out_data_reg;
    logic                   out_valid_reg;
    logic                   out_last_reg;
    logic                   out_user_reg;
    logic                   frame_done_reg, frame_done_next;
    logic                   truncated_reg, truncated_next;

    // Per-port views of the packed source buses
    logic [7:0]             port_data [PORTS];
    logic                   port_valid [PORTS];
    logic                   port_last [PORTS];
    logic                   port_user [PORTS];

    // Granted-source signals
    logic [7:0]             cur_data;
    logic                   cur_valid;
    logic                   cur_last;
    logic                   cur_user;
    logic                   cur_ready;

    // Output register load control
    logic                   load;
    logic                   load_last;
    logic                   load_user;

    // Round-robin selection result
    logic                   sel_found;
    logic [SEL_WIDTH-1:0]   sel_idx;

    genvar gi;
    generate
        for (gi = 0; gi < PORTS; gi++) begin : g_port
            assign port_data[gi]  = s_axis_tdata[gi*8 +: 8];
            assign port_valid[gi] = s_axis_tvalid[gi];
            assign port_last[gi]  = s_axis_tlast[gi];
            assign port_user[gi]  = s_axis_tuser[gi];
            // Only the granted port can ever see ready.
            assign s_axis_tready[gi] = cur_ready && (grant_reg == SEL_WIDTH'(gi));
        end
    endgenerate

    assign cur_data  = port_data[grant_reg];
    assign cur_valid = port_valid[grant_reg];
    assign cur_last  = port_last[grant_reg];
    assign cur_user  = port_user[grant_reg];

    // Search upward from last_grant+1 (modulo PORTS). Iterating the offset
    // downward lets the nearest valid port overwrite any farther candidate.
    always_comb begin
        int cand;
        sel_found = 1'b0;
        sel_idx   = '0;
        cand      = 0;
        for (int k = PORTS; k >= 1; k--) begin
            cand = (int'(last_grant_reg) + k) % PORTS;
            if (s_axis_tvalid[SEL_WIDTH'(cand)]) begin
                sel_found = 1'b1;
                sel_idx   = SEL_WIDTH'(cand);
            end
        end
    end

    // Next-state and control
    always_comb begin
        state_next      = state_reg;
        grant_next      = grant_reg;
        last_grant_next = last_grant_reg;
        count_next      = count_reg;
        cur_ready       = 1'b0;
        load            = 1'b0;
        load_last       = cur_last;
        load_user       = cur_user;
        frame_done_next = 1'b0;
        truncated_next  = 1'b0;

        case (state_reg)
            ST_IDLE: begin
                if (sel_found) begin
                    grant_next      = sel_idx;
                    last_grant_next = sel_idx;
                    count_next      = '0;
                    state_next      = ST_PASS;
                end
            end

            ST_PASS: begin
                // Single output register: accept when empty or draining.
                cur_ready = !out_valid_reg || m_axis_tready;
                if (cur_ready && cur_valid) begin
                    load = 1'b1;
                    if (cur_last) begin
                        // tlast wins over truncation, so an exactly
                        // MAX_FRAME_LEN-beat frame passes intact.
                        frame_done_next = 1'b1;
                        state_next      = ST_IDLE;
                    end else if (count_reg == LEN_WIDTH'(MAX_FRAME_LEN - 1)) begin
                        load_last      = 1'b1;
                        load_user      = 1'b1;
                        truncated_next = 1'b1;
                        state_next     = ST_DISCARD;
                    end else begin
                        count_next = count_reg + LEN_WIDTH'(1);
                    end
                end
            end

            ST_DISCARD: begin
                cur_ready = 1'b1;
                if (cur_valid && cur_last) begin
                    state_next = ST_IDLE;
                end
            end

            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    // State register
    always_ff @(posedge logic_clk or posedge logic_rst) begin
        if (logic_rst) begin
            state_reg      <= ST_IDLE;
            grant_reg      <= '0;
            last_grant_reg <= SEL_WIDTH'(PORTS - 1);
            count_reg      <= '0;
            frame_done_reg <= 1'b0;
            truncated_reg  <= 1'b0;
        end else begin
            state_reg      <= state_next;
            grant_reg      <= grant_next;
            last_grant_reg <= last_grant_next;
            count_reg      <= count_next;
            frame_done_reg <= frame_done_next;
            truncated_reg  <= truncated_next;
        end
    end

    // Output register
    always_ff @(posedge logic_clk or posedge logic_rst) begin
        if (logic_rst) begin
            out_data_reg  <= '0;
            out_valid_reg <= 1'b0;
            out_last_reg  <= 1'b0;
            out_user_reg  <= 1'b0;
        end else if (load) begin
            out_data_reg  <= cur_data;
            out_valid_reg <= 1'b1;
            out_last_reg  <= load_last;
            out_user_reg  <= load_user;
        end else if (m_axis_tready) begin
            out_valid_reg <= 1'b0;
        end
    end

    assign m_axis_tdata      = out_data_reg;
    assign m_axis_tvalid     = out_valid_reg;
    assign m_axis_tlast      = out_last_reg;
    assign m_axis_tuser      = out_user_reg;
    assign grant_port        = grant_reg;
    assign busy              = (state_reg != ST_IDLE);
    assign status_frame_done = frame_done_reg;
    assign status_truncated  = truncated_reg;

endmodule

// File: tb/tb_eth_tx_frame_arbiter.sv
// ---------------------------------------------------------------------------
// tb_eth_tx_frame_arbiter
//
// Self-checking bench for eth_tx_frame_arbiter (PORTS=3, MAX_FRAME_LEN=16).
// Source frames are queued per port; a reference model computes the expected
// merged output stream from the round-robin / truncation rules and the
// captured output is compared frame by frame.
// ---------------------------------------------------------------------------
module tb_eth_tx_frame_arbiter;

    localparam int P    = 3;
    localparam int MAXL = 16;
    localparam int SW   = 2;

    logic             clk = 1'b0;
    logic             rst;
    logic [P*8-1:0]   s_tdata;
    logic [P-1:0]     s_tvalid, s_tready, s_tlast, s_tuser;
    logic [7:0]       m_tdata;
    logic             m_tvalid, m_tready, m_tlast, m_tuser;
    logic [SW-1:0]    grant_port;
    logic             busy, done_p, trunc_p;

    always #5 clk = ~clk;

    eth_tx_frame_arbiter #(
        .PORTS         (P),
        .MAX_FRAME_LEN (MAXL)
    ) dut (
        .logic_clk         (clk),
        .logic_rst         (rst),
        .s_axis_tdata      (s_tdata),
        .s_axis_tvalid     (s_tvalid),
        .s_axis_tready     (s_tready),
        .s_axis_tlast      (s_tlast),
        .s_axis_tuser      (s_tuser),
        .m_axis_tdata      (m_tdata),
        .m_axis_tvalid     (m_tvalid),
        .m_axis_tready     (m_tready),
        .m_axis_tlast      (m_tlast),
        .m_axis_tuser      (m_tuser),
        .grant_port        (grant_port),
        .busy              (busy),
        .status_frame_done (done_p),
        .status_truncated  (trunc_p)
    );

    int checks   = 0;
    int failures = 0;

    // Source beat storage: {tuser, tlast, tdata}
    logic [9:0] mem [P][512];
    bit         fstart [P][512];
    int         wr [P];
    int         rd [P];
    bit         held [P];
    int         frm_len [P][32];
    int         frm_base [P][32];
    int         frm_cnt [P];

    // Captured and expected output streams
    logic [9:0] cap_q [$];
    int         cap_cyc [$];
    logic [9:0] exp_q [$];
    int         exp_first [$];
    int         exp_done, exp_trunc;
    int         mdl_lg;

    int cnt_done, cnt_trunc, stall_bad, onehot_bad, first_valid_cyc;
    bit rand_ready, rand_gaps, timed_out;

    task automatic clear_sources();
        for (int p = 0; p < P; p++) begin
            wr[p] = 0; rd[p] = 0; frm_cnt[p] = 0; held[p] = 1'b0;
        end
    endtask

    task automatic add_frame(input int p, input int len, input bit user);
        logic [7:0] d;
        frm_len[p][frm_cnt[p]]  = len;
        frm_base[p][frm_cnt[p]] = wr[p];
        frm_cnt[p]++;
        for (int b = 0; b < len; b++) begin
            d = 8'($urandom);
            mem[p][wr[p]]    = {(b == len - 1) ? user : 1'b0, (b == len - 1), d};
            fstart[p][wr[p]] = (b == 0);
            wr[p]++;
        end
    endtask

    // Reference model: frames leave in round-robin order among ports that
    // still have frames; frames longer than MAXL are cut to MAXL beats with
    // the final beat flagged last+bad.
    task automatic build_expected();
        int taken [P];
        int total, p, len, n_out, base;
        logic [9:0] w;
        exp_q.delete(); exp_first.delete();
        exp_done = 0; exp_trunc = 0; total = 0;
        for (int i = 0; i < P; i++) begin
            taken[i] = 0;
            total += frm_cnt[i];
        end
        for (int n = 0; n < total; n++) begin
            p = mdl_lg;
            do p = (p + 1) % P; while (taken[p] >= frm_cnt[p]);
            mdl_lg = p;
            len  = frm_len[p][taken[p]];
            base = frm_base[p][taken[p]];
            taken[p]++;
            n_out = (len > MAXL) ? MAXL : len;
            if (len > MAXL) exp_trunc++; else exp_done++;
            exp_first.push_back(exp_q.size());
            for (int b = 0; b < n_out; b++) begin
                w = mem[p][base + b];
                if (len > MAXL && b == n_out - 1) w[9:8] = 2'b11;
                exp_q.push_back(w);
            end
        end
    endtask

    // Cycle loop: drive at negedge, sample 1 time unit later.
    task automatic run(input int budget, input int stop_after);
        int  quiet;
        bit  prev_stall, drained, v;
        logic [10:0] prev_out;
        quiet = 0; prev_stall = 1'b0; prev_out = '0;
        cap_q.delete(); cap_cyc.delete();
        cnt_done = 0; cnt_trunc = 0; stall_bad = 0; onehot_bad = 0;
        first_valid_cyc = -1;
        timed_out = 1'b1;
        for (int c = 0; c < budget; c++) begin
            @(negedge clk);
            m_tready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
            for (int p = 0; p < P; p++) begin
                if (rd[p] < wr[p]) begin
                    v = held[p] || fstart[p][rd[p]] || !rand_gaps || ($urandom_range(0, 3) != 0);
                    s_tvalid[p] = v;
                    {s_tuser[p], s_tlast[p], s_tdata[p*8 +: 8]} = mem[p][rd[p]];
                end else begin
                    s_tvalid[p] = 1'b0;
                    s_tlast[p]  = 1'b0;
                    s_tuser[p]  = 1'b0;
                    s_tdata[p*8 +: 8] = 8'($urandom);
                end
            end
            #1;
            if (first_valid_cyc < 0 && (|s_tvalid)) first_valid_cyc = c;
            if ($countones(s_tready) > 1) onehot_bad++;
            if (prev_stall && ({m_tvalid, m_tlast, m_tuser, m_tdata} !== prev_out)) stall_bad++;
            prev_out   = {m_tvalid, m_tlast, m_tuser, m_tdata};
            prev_stall = m_tvalid && !m_tready;
            if (m_tvalid && m_tready) begin
                cap_q.push_back({m_tuser, m_tlast, m_tdata});
                cap_cyc.push_back(c);
            end
            if (done_p)  cnt_done++;
            if (trunc_p) cnt_trunc++;
            for (int p = 0; p < P; p++) begin
                if (s_tvalid[p]) begin
                    if (s_tready[p]) begin
                        rd[p]++;
                        held[p] = 1'b0;
                    end else begin
                        held[p] = 1'b1;
                    end
                end
            end
            if (stop_after > 0 && cap_q.size() >= stop_after) begin
                timed_out = 1'b0;
                break;
            end
            drained = (cap_q.size() >= exp_q.size());
            for (int p = 0; p < P; p++) if (rd[p] < wr[p]) drained = 1'b0;
            if (drained) quiet++; else quiet = 0;
            if (quiet >= 3) begin
                timed_out = 1'b0;
                break;
            end
        end
    endtask

    task automatic check_run(input string name, input bit strict);
        int lo, hi, bad, left;
        checks++;
        if (timed_out !== 1'b0) begin
            failures++;
            $display("FAIL %s timeout: captured %0d beats, required %0d", name, cap_q.size(), exp_q.size());
        end
        checks++;
        if (cap_q.size() != exp_q.size()) begin
            failures++;
            $display("FAIL %s beat_count: got %0d required %0d", name, cap_q.size(), exp_q.size());
        end else begin
            for (int k = 0; k < exp_first.size(); k++) begin
                lo  = exp_first[k];
                hi  = (k + 1 < exp_first.size()) ? exp_first[k + 1] : exp_q.size();
                bad = -1;
                for (int i = lo; i < hi; i++)
                    if (bad < 0 && cap_q[i] !== exp_q[i]) bad = i;
                checks++;
                if (bad >= 0) begin
                    failures++;
                    $display("FAIL %s frame%0d beat%0d {user,last,data}: got %h required %h",
                             name, k, bad - lo, cap_q[bad], exp_q[bad]);
                end
                if (strict && k > 0) begin
                    checks++;
                    if (cap_cyc[lo] - cap_cyc[lo - 1] != 2) begin
                        failures++;
                        $display("FAIL %s gap frame%0d: got %0d cycles required 2",
                                 name, k, cap_cyc[lo] - cap_cyc[lo - 1]);
                    end
                end
            end
        end
        checks++;
        if (cnt_done != exp_done) begin
            failures++;
            $display("FAIL %s frame_done_pulses: got %0d required %0d", name, cnt_done, exp_done);
        end
        checks++;
        if (cnt_trunc != exp_trunc) begin
            failures++;
            $display("FAIL %s truncated_pulses: got %0d required %0d", name, cnt_trunc, exp_trunc);
        end
        checks++;
        if (stall_bad != 0) begin
            failures++;
            $display("FAIL %s stall_stability: got %0d unstable cycles required 0", name, stall_bad);
        end
        checks++;
        if (onehot_bad != 0) begin
            failures++;
            $display("FAIL %s ready_onehot: got %0d multi-ready cycles required 0", name, onehot_bad);
        end
        left = 0;
        for (int p = 0; p < P; p++) left += wr[p] - rd[p];
        checks++;
        if (left != 0) begin
            failures++;
            $display("FAIL %s sources_drained: got %0d beats left required 0", name, left);
        end
        $display("%s: frames=%0d beats=%0d done=%0d trunc=%0d", name, exp_first.size(), cap_q.size(), cnt_done, cnt_trunc);
    endtask

    task automatic check_outputs_zero(input string name);
        checks++;
        if ({m_tdata, m_tvalid, m_tlast, m_tuser, s_tready, grant_port, busy, done_p, trunc_p} !== '0) begin
            failures++;
            $display("FAIL %s outputs: got data=%h v=%b l=%b u=%b rdy=%b gp=%0d busy=%b done=%b trunc=%b required all 0",
                     name, m_tdata, m_tvalid, m_tlast, m_tuser, s_tready, grant_port, busy, done_p, trunc_p);
        end
        $display("%s: reset output check", name);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        s_tvalid = '0; s_tlast = '0; s_tuser = '0; s_tdata = '0; m_tready = 1'b1;
        rand_ready = 1'b0; rand_gaps = 1'b0;
        mdl_lg = P - 1;
        clear_sources();
        repeat (3) @(negedge clk);
        #1;
        check_outputs_zero("reset");
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_single();
        clear_sources();
        add_frame(0, 12, 1'b0);
        build_expected();
        run(200, 0);
        check_run("single", 1'b0);
        checks++;
        if (cap_cyc.size() == 0 || cap_cyc[0] - first_valid_cyc != 2) begin
            failures++;
            $display("FAIL single latency: got %0d cycles required 2",
                     (cap_cyc.size() == 0) ? -1 : cap_cyc[0] - first_valid_cyc);
        end
    endtask

    task automatic test_round_robin();
        clear_sources();
        for (int f = 0; f < 3; f++)
            for (int p = 0; p < P; p++) add_frame(p, 10, 1'b0);
        build_expected();
        run(500, 0);
        check_run("round_robin", 1'b1);
    endtask

    task automatic test_truncate();
        clear_sources();
        add_frame(1, 20, 1'b0);
        add_frame(2, 5, 1'b0);
        add_frame(0, 5, 1'b1);
        build_expected();
        run(300, 0);
        check_run("truncate", 1'b0);
    endtask

    task automatic test_exact_max();
        clear_sources();
        add_frame(0, MAXL, 1'b0);
        add_frame(2, MAXL, 1'b1);
        add_frame(1, MAXL + 1, 1'b0);
        build_expected();
        run(300, 0);
        check_run("exact_max", 1'b0);
    endtask

    task automatic test_backpressure();
        rand_ready = 1'b1; rand_gaps = 1'b1;
        for (int it = 0; it < 3; it++) begin
            clear_sources();
            for (int p = 0; p < P; p++)
                for (int f = 0; f < 2; f++)
                    add_frame(p, $urandom_range(1, 24), 1'($urandom_range(0, 1)));
            build_expected();
            run(3000, 0);
            check_run("backpressure", 1'b0);
        end
        rand_ready = 1'b0; rand_gaps = 1'b0;
    endtask

    task automatic test_reset_midframe();
        // Port 1 mid-frame when reset hits; afterwards port 0 must win first.
        clear_sources();
        add_frame(1, 12, 1'b0);
        build_expected();
        run(200, 5);
        rst = 1'b1;
        #1;
        check_outputs_zero("reset_midframe");
        @(negedge clk);
        rst = 1'b0;
        s_tvalid = '0;
        mdl_lg = P - 1;
        clear_sources();
        for (int p = 0; p < P; p++) add_frame(p, 6, 1'b0);
        build_expected();
        run(300, 0);
        check_run("after_reset", 1'b1);
    endtask

    initial begin
        test_reset();
        test_single();
        test_round_robin();
        test_truncate();
        test_exact_max();
        test_backpressure();
        test_reset_midframe();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
